// File: rtl/sic4_control.sv
// sic4_control -- multi-cycle control unit for the SIC-4 8-bit processor.
//
// Sequences FETCH / DECODE / EXEC / MEM / WB over one shared memory port and
// drives every input of the 4x8 register file. Outputs are decoded from the
// state register, so an asynchronous reset drops mem_req and write at once.
//
// Parameters:
//   RESET_PC      program counter value loaded on reset
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   mem_req       memory request, held until mem_ready
//   mem_we        1 = write, 0 = read (valid with mem_req)
//   mem_addr      memory address (pc in FETCH, reg[rt] in MEM)
//   mem_wdata     store data (reg[rs]) in MEM
//   mem_rdata     read data, valid when mem_ready is high
//   mem_ready     request completes at this rising edge
//   r_read1/2     register file read selects (rs / rt)
//   r_read1_data  register file read data for rs
//   r_read2_data  register file read data for rt
//   r_write       register file write select (rs)
//   r_write_data  register file write data
//   write         register file write enable (WB only)
//   alu_func      ALU function (ir[5:4])
//   alu_result    external ALU result
//   pc            program counter
//   halted        core halted (left only by reset)
//   retired       retired-instruction count, only when SIC4_RETIRE_COUNT_EN
//                 is defined
`timescale 1ns/1ps
module sic4_control #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic [1:0]  r_read1,
    output logic [1:0]  r_read2,
    input  logic [7:0]  r_read1_data,
    input  logic [7:0]  r_read2_data,
    output logic [1:0]  r_write,
    output logic [7:0]  r_write_data,
    output logic        write,
    output logic [1:0]  alu_func,
    input  logic [7:0]  alu_result,
    output logic [7:0]  pc,
    output logic        halted
`ifdef SIC4_RETIRE_COUNT_EN
    ,
    output logic [15:0] retired
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [1:0] {
        OP_ALU = 2'b00, OP_LOAD = 2'b01, OP_STORE = 2'b10, OP_CTRL = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        C_JMP = 2'b00, C_BEZ = 2'b01, C_NOP = 2'b10, C_HALT = 2'b11
    } ctrl_t;

    state_t     state, state_next;
    logic [7:0] ir, ir_next;
    logic [7:0] wb_data, wb_next;
    logic [7:0] pc_next;
    op_t        op;
    ctrl_t      sub;

    assign op  = op_t'(ir[7:6]);
    assign sub = ctrl_t'(ir[5:4]);

    // Register-file selects follow the instruction register directly; ir is
    // only loaded in FETCH so they stay stable from DECODE through WB/MEM.
    assign r_read1      = ir[3:2];
    assign r_read2      = ir[1:0];
    assign alu_func     = ir[5:4];
    assign r_write      = ir[3:2];
    assign r_write_data = wb_data;
    assign halted       = (state == S_HALT);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            ir      <= '0;
            wb_data <= '0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            ir      <= ir_next;
            wb_data <= wb_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a value held (no latches).
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        wb_next    = wb_data;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 8'h00;
        mem_wdata  = 8'h00;
        write      = 1'b0;

        unique case (state)
            S_IDLE: state_next = S_FETCH;

            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
                if (mem_ready) begin
                    ir_next    = mem_rdata;
                    pc_next    = pc + 8'd1;   // wraps 8'hFF -> 8'h00
                    state_next = S_DECODE;
                end
            end

            S_DECODE: state_next = S_EXEC;

            S_EXEC: begin
                unique case (op)
                    OP_ALU: begin
                        wb_next    = alu_result;
                        state_next = S_WB;
                    end
                    OP_LOAD, OP_STORE: state_next = S_MEM;
                    OP_CTRL: begin
                        // Branch targets overwrite the already-incremented pc.
                        state_next = S_FETCH;
                        unique case (sub)
                            C_JMP:  pc_next = r_read1_data;
                            C_BEZ:  if (r_read1_data == 8'h00) pc_next = r_read2_data;
                            C_NOP:  ;
                            C_HALT: state_next = S_HALT;
                        endcase
                    end
                endcase
            end

            S_MEM: begin
                mem_req   = 1'b1;
                mem_we    = (op == OP_STORE);
                mem_addr  = r_read2_data;
                mem_wdata = r_read1_data;
                if (mem_ready) begin
                    if (op == OP_STORE) begin
                        state_next = S_FETCH;
                    end else begin
                        wb_next    = mem_rdata;
                        state_next = S_WB;
                    end
                end
            end

            S_WB: begin
                write      = 1'b1;
                state_next = S_FETCH;
            end

            S_HALT: state_next = S_HALT;

            default: state_next = S_IDLE;
        endcase
    end

`ifdef SIC4_RETIRE_COUNT_EN
    // An instruction retires on the edge leaving its final state: WB, MEM for
    // a completed store, or EXEC for any control-class opcode.
    logic retire;
    assign retire = (state == S_WB)
                 || (state == S_MEM && mem_ready && op == OP_STORE)
                 || (state == S_EXEC && op == OP_CTRL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + 16'd1;
        end
    end
`endif

endmodule

// File: doc/sic4_control.md
# sic4_control

Multi-cycle control unit for the SIC-4 8-bit processor; sits directly upstream of the 4×8 register file. Sequences fetch/decode/execute/writeback over a single shared memory port and drives every register-file input (read selects, write select, write data, write enable). Consumes the register file's two read ports and an external ALU result.

## Interface
Parameters:
- RESET_PC, 8'h00, program counter value loaded on reset.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory request; held until accepted.
- mem_we  out  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  out  8  memory address.
- mem_wdata  out  8  store data.
- mem_rdata  in  8  read data; valid in the cycle mem_ready is high.
- mem_ready  in  1  request accepted/completed at this rising edge.
- r_read1  out  2  register file read select 1 (rs = ir[3:2]).
- r_read2  out  2  register file read select 2 (rt = ir[1:0]).
- r_read1_data  in  8  register file read data 1 (combinational).
- r_read2_data  in  8  register file read data 2 (combinational).
- r_write  out  2  register file write select.
- r_write_data  out  8  register file write data.
- write  out  1  register file write enable.
- alu_func  out  2  ALU function (ir[5:4]); ALU operands are r_read1_data, r_read2_data.
- alu_result  in  8  external ALU result.
- pc  out  8  program counter.
- halted  out  1  core halted.
- retired  out  16  retired-instruction count (present only with SIC4_RETIRE_COUNT_EN).

## Operation
- Instruction: op = ir[7:6], sub = ir[5:4], rs = ir[3:2], rt = ir[1:0].
  - op 00 ALU: rs <- alu(func=sub, rs, rt).
  - op 01 LOAD: rs <- mem[reg[rt]].
  - op 10 STORE: mem[reg[rt]] <- reg[rs].
  - op 11: sub 00 JMP pc <- reg[rs]; sub 01 BEZ if reg[rs]==0 then pc <- reg[rt]; sub 10 NOP; sub 11 HALT.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
  - IDLE -> FETCH unconditionally (one cycle after reset release).
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ready: ir <- mem_rdata, pc <- pc+1 (8-bit wrap, 8'hFF -> 8'h00), -> DECODE. Otherwise stay.
  - DECODE: r_read1/r_read2 from ir; -> EXEC.
  - EXEC: ALU -> WB with wb_data <- alu_result; LOAD/STORE -> MEM; JMP/BEZ-taken load pc -> FETCH; BEZ-not-taken/NOP -> FETCH; HALT -> HALT.
  - MEM: mem_req=1, mem_addr=reg[rt], mem_we=(op==10), mem_wdata=reg[rs]. On mem_ready: LOAD wb_data <- mem_rdata, -> WB; STORE -> FETCH.
  - WB: write=1, r_write=rs, r_write_data=wb_data for exactly one cycle; -> FETCH.
  - HALT: halted=1, no requests; exits only by reset.
- r_read1/r_read2 always reflect ir fields (stable from DECODE through WB/MEM).
- write is 1 only in WB; mem_req is 1 only in FETCH and MEM.

## Timing
- Reset (async, immediate): state=IDLE, pc=RESET_PC, ir=0, wb_data=0, halted=0, retired=0; mem_req, mem_we, write=0; mem_addr, mem_wdata, r_write, r_write_data, alu_func, r_read1, r_read2=0.
- Reset asserted mid-transaction: mem_req drops combinationally; in-flight write is abandoned (write low before next edge).
- Handshake: mem_addr/mem_we/mem_wdata stable while mem_req=1 until the edge sampling mem_ready=1; mem_ready ignored when mem_req=0. Wait states extend FETCH/MEM by one cycle each.
- Cycles with mem_ready tied high: ALU 4, LOAD 5, STORE 4, JMP/BEZ/NOP 3 (FETCH, DECODE, EXEC).
- Register write commits at the rising edge ending WB; the next instruction's DECODE sees the new value (no hazard).
- JMP/BEZ targets overwrite the already-incremented pc.

## Configuration
- SIC4_RETIRE_COUNT_EN defined: retired port exists; increments by 1 at the edge leaving WB, leaving MEM for STORE, or leaving EXEC for JMP/BEZ/NOP/HALT; wraps 16'hFFFF -> 0; frozen in HALT.
- Undefined: retired port and counter absent; all other behaviour identical.

## Test plan
- Reset then mem_ready=1, mem[0]=8'h01 (ALU add r0,r1), reg0=2, reg1=3, alu_result=5 -> mem_addr=0 in FETCH, write=1, r_write=0, r_write_data=8'h05 in cycle 4 after FETCH start, pc=1.
- LOAD 8'h45 (r1 <- mem[r1]), reg1=8'h20, mem[20]=8'hA1, mem_ready delayed 2 cycles in MEM -> mem_addr=8'h20, mem_we=0 held 3 cycles, then write=1, r_write=1, r_write_data=8'hA1.
- STORE 8'h8E (mem[r2] <- r3), reg2=8'h30, reg3=8'h55 -> mem_we=1, mem_addr=8'h30, mem_wdata=8'h55, write never asserted.
- BEZ 8'hD4 (rs=1, rt=0) with reg1=0, reg0=8'h40 -> next fetch mem_addr=8'h40; with reg1=1 -> next fetch at pc+1; pc=8'hFF fetch wraps pc to 8'h00.
- HALT 8'hF0 -> halted=1, mem_req stays 0 for 20 cycles; rst_n low mid-MEM -> mem_req and write drop immediately, pc=RESET_PC.
- With SIC4_RETIRE_COUNT_EN: run ALU, LOAD, STORE, NOP, HALT -> retired=5 and holds.
